char_write_arbiter: RTL and testbench
=====================================

// Module: char_write_arbiter
// PURPOSE
//  Round-robin arbiter and write sequencer for the text-screen character RAM write port (addr/data/nWr).
//  Several requesters share the port: score updater, message writer, debug overlay and so on.
//  Each requester makes a req/ack request; the block serialises requests into clean setup/strobe/hold cycles.
//  Sits between the game-logic writers and txtScreen, inside the VGA controller clock domain.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  ADDR_W   12  character RAM address width
//  DATA_W   8   character code width
// PORTS
//  iVGA_CLK    in   1               pixel clock; all logic on posedge
//  iRST_n      in   1               asynchronous, active-low reset
//  iReq        in   NUM_REQ         per-requester write request; hold until matching oAck
//  iAddr       in   NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
//  iData       in   NUM_REQ*DATA_W  packed char codes; requester i at [i*DATA_W +: DATA_W]
//  iBLANK_n    in   1               video blank from sync generator; 0 = blanking
//  oAck        out  NUM_REQ         one-cycle completion pulse, one-hot
//  oCharAddr   out  ADDR_W          to txtScreen addr
//  oCharData   out  DATA_W          to txtScreen data
//  oChar_nWr   out  1               to txtScreen nWr, active-low write strobe
//  oBusy       out  1               1 when state != IDLE
// BEHAVIOUR
//  - Reset values: oChar_nWr=1, oCharAddr=0, oCharData=0, oAck=0, oBusy=0, state=IDLE, last=NUM_REQ-1.
//    With last=NUM_REQ-1, requester 0 has first priority after reset.
//  - All outputs are registered. Reset is asynchronous: asserting it mid-write drives oChar_nWr=1 and oAck=0 immediately.
//    The aborted write is not acked and is not retried by the block; the requester re-issues it.
//  - FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE:
//    IDLE: if any iReq is eligible, grant g = first set bit searching from last+1 with wrap-around.
//          Latch iAddr[g] and iData[g] into oCharAddr/oCharData; nWr=1; go to SETUP.
//    SETUP:  nWr=0; go to STROBE. The strobe is low for exactly 1 cycle.
//    STROBE: nWr=1; oAck[g]=1; last=g; go to HOLD.
//    HOLD:   oAck=0; go to IDLE. Addr/data remain stable through HOLD.
//  - Latency: request sampled at edge E0. nWr is low between E1 and E2. oAck is high between E2 and E3.
//    Minimum period per write is 4 cycles, since IDLE lasts 1 cycle.
//  - Requester samples oAck=1 and drops or changes iReq on that same edge.
//    A req still high in the following IDLE is a new write with the current iAddr/iData.
//  - Req dropped after the grant: the write still completes and oAck still pulses. The grant is committed.
//  - Req changes during SETUP/STROBE/HOLD are ignored. Addr/data were latched in IDLE.
//  - oCharAddr/oCharData hold their last values while IDLE. They are never cleared except by reset.
//  - No starvation: with all NUM_REQ requests held continuously, grants cycle 0,1,..,NUM_REQ-1,0.
// CONFIGURATION
//  Macro CHARWR_BLANK_ONLY_EN:
//   defined: IDLE grants only while iBLANK_n==0. A started sequence always completes, even if blanking ends.
//            This prevents visible tearing of the text layer.
//   undefined: iBLANK_n is ignored. The port stays present and is tied off by the user as needed.
// STRUCTURE
//  - Package vga_pkg:
//    - state enum {IDLE, SETUP, STROBE, HOLD}
//    - VIDEO_W=640 and VIDEO_H=480
//    - text address constants SCORE1_ADDR=12'h05C and SCORE2_ADDR=12'h069
//    - CHAR_ZERO=8'h30
//  - Sub-module rr_arbiter: combinational round-robin select.
//    Inputs: req vector, last grant. Outputs: one-hot grant and grant index.
//  - Top level: FSM plus output registers.
// TESTING
//  1. Single write: after reset, iReq=0001, addr0=12'h05C, data0=8'h33.
//     -> addr/data valid at E0+, nWr low for exactly one cycle, oAck=0001 for one cycle, oBusy high 3 cycles.
//  2. Simultaneous requests: iReq=0101 held, each requester dropping its req on its ack.
//     -> writes in order req0 then req2. All four held -> grant order 0,1,2,3,0.
//  3. Back-to-back from one requester: req1 held across its ack with new data 8'h35.
//     -> second strobe starts 4 cycles after the first, carrying 8'h35.
//  4. Reset mid-write: assert iRST_n=0 while nWr=0.
//     -> nWr=1 and oAck=0 immediately. After release, the held req0 is granted first.
//  5. CHARWR_BLANK_ONLY_EN defined: req during active video (iBLANK_n=1).
//     -> no grant until iBLANK_n=0, then the write completes even if iBLANK_n rises mid-sequence.
//     Macro undefined -> grant on the next edge.
//  6. Withdrawn request: req3 dropped one cycle after the grant.
//     -> write to addr3 still occurs and oAck=1000 pulses. No spurious second write.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA-domain types and constants: write-sequencer states,
// screen geometry, text-screen score locations and the ASCII digit base.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int VIDEO_W = 640;
    localparam int VIDEO_H = 480;

    localparam logic [11:0] SCORE1_ADDR = 12'h05C;
    localparam logic [11:0] SCORE2_ADDR = 12'h069;

    localparam logic [7:0] CHAR_ZERO = 8'h30;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first set req bit after last, wrapping.
// Ports: req (N), last (IDX_W) in; gnt one-hot (N), gnt_idx (IDX_W), any out.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/char_write_arbiter.sv
// Round-robin arbiter + setup/strobe/hold write sequencer for the character RAM port.
// Ports: iVGA_CLK, iRST_n (async low), iReq, iAddr, iData, iBLANK_n in;
// oAck, oCharAddr, oCharData, oChar_nWr, oBusy out (all registered).
// Macro CHARWR_BLANK_ONLY_EN: when defined, new writes start only during blanking.
module char_write_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8
) (
    input  logic                      iVGA_CLK,
    input  logic                      iRST_n,
    input  logic [NUM_REQ-1:0]        iReq,
    input  logic [NUM_REQ*ADDR_W-1:0] iAddr,
    input  logic [NUM_REQ*DATA_W-1:0] iData,
    input  logic                      iBLANK_n,
    output logic [NUM_REQ-1:0]        oAck,
    output logic [ADDR_W-1:0]         oCharAddr,
    output logic [DATA_W-1:0]         oCharData,
    output logic                      oChar_nWr,
    output logic                      oBusy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     last, last_nxt;
    logic [NUM_REQ-1:0]   gnt_q, gnt_nxt;
    logic [ADDR_W-1:0]    addr_nxt;
    logic [DATA_W-1:0]    data_nxt;
    logic                 nwr_nxt;
    logic [NUM_REQ-1:0]   ack_nxt;
    logic                 busy_nxt;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 grant_ok;

`ifdef CHARWR_BLANK_ONLY_EN
    // Only start during blanking; a started sequence runs to completion.
    assign grant_ok = !iBLANK_n;
`else
    logic unused_blank;
    assign unused_blank = iBLANK_n;
    assign grant_ok     = 1'b1;
`endif

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (iReq),
        .last    (last),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        gnt_nxt   = gnt_q;
        addr_nxt  = oCharAddr;
        data_nxt  = oCharData;
        nwr_nxt   = 1'b1;
        ack_nxt   = '0;
        unique case (state)
            IDLE: begin
                if (arb_any && grant_ok) begin
                    gnt_nxt   = arb_gnt;
                    last_nxt  = last;
                    addr_nxt  = iAddr[int'(arb_idx)*ADDR_W +: ADDR_W];
                    data_nxt  = iData[int'(arb_idx)*DATA_W +: DATA_W];
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                nwr_nxt   = 1'b0;
                state_nxt = STROBE;
            end
            STROBE: begin
                ack_nxt   = gnt_q;
                state_nxt = HOLD;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (gnt_q[i]) last_nxt = IDX_W'(i);
                end
            end
            HOLD: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state     <= IDLE;
            last      <= IDX_W'(NUM_REQ - 1);
            gnt_q     <= '0;
            oCharAddr <= '0;
            oCharData <= '0;
            oChar_nWr <= 1'b1;
            oAck      <= '0;
            oBusy     <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            gnt_q     <= gnt_nxt;
            oCharAddr <= addr_nxt;
            oCharData <= data_nxt;
            oChar_nWr <= nwr_nxt;
            oAck      <= ack_nxt;
            oBusy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_char_write_arbiter.sv
// Bench for char_write_arbiter: vector table of request patterns,
// write scoreboard, and hand sequences for timing/reset/blank corners.
module tb_char_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [47:0] addr;
    logic [31:0] data;
    logic        blank_n;
    logic [3:0]  ack;
    logic [11:0] caddr;
    logic [7:0]  cdata;
    logic        nwr;
    logic        busy;

    char_write_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (12),
        .DATA_W  (8)
    ) dut (
        .iVGA_CLK  (clk),
        .iRST_n    (rst_n),
        .iReq      (req),
        .iAddr     (addr),
        .iData     (data),
        .iBLANK_n  (blank_n),
        .oAck      (ack),
        .oCharAddr (caddr),
        .oCharData (cdata),
        .oChar_nWr (nwr),
        .oBusy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [11:0] a;
        logic [7:0]  d;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         n;
        logic [7:0] ord;
    } vec_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [3:0] exp_ack;
    bit   ack_due = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input int i);
        exp_t e;
        e.idx = i;
        e.a   = addr[i*12 +: 12];
        e.d   = data[i*8 +: 8];
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ack_due = 0;
        end else begin
            if (ack_due) begin
                chk("ack_pulse", {28'd0, ack}, {28'd0, exp_ack});
                chk("strobe_width", {31'd0, nwr}, 32'd1);
                ack_due = 0;
            end else if (ack != 4'd0) begin
                chk("spurious_ack", {28'd0, ack}, 32'd0);
            end
            if (!nwr) begin
                n_chk++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h", caddr, cdata);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_addr", {20'd0, caddr}, {20'd0, e.a});
                    chk("wr_data", {24'd0, cdata}, {24'd0, e.d});
                    exp_ack = 4'(1 << e.idx);
                    ack_due = 1;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input logic [3:0] mask, input int nacks, input bit drop);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        @(negedge clk);
        req = mask;
        while (got < nacks && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ack != 4'd0) begin
                got++;
                if (drop) req = req & ~ack;
                if (got == nacks) req = 4'd0;
            end
        end
        if (got < nacks) chk("run_timeout", got, nacks);
        repeat (4) @(negedge clk);
    endtask

    vec_t vt[7];

    initial begin
        int s1, s2, cyc, nack;
        bit seen;
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2, cyc, nack;
        rst_n   = 1'b0;
        req     = 4'd0;
        addr    = '0;
        data    = '0;
        blank_n = 1'b0;

        vt[0] = '{4'b0101, 2, {2'd0, 2'd0, 2'd2, 2'd0}};
        vt[1] = '{4'b0001, 1, {2'd0, 2'd0, 2'd0, 2'd0}};
        vt[2] = '{4'b1010, 2, {2'd0, 2'd0, 2'd3, 2'd1}};
        vt[3] = '{4'b0110, 2, {2'd0, 2'd0, 2'd2, 2'd1}};
        vt[4] = '{4'b1111, 4, {2'd2, 2'd1, 2'd0, 2'd3}};
        vt[5] = '{4'b1001, 2, {2'd0, 2'd0, 2'd0, 2'd3}};
        vt[6] = '{4'b0010, 1, {2'd0, 2'd0, 2'd0, 2'd1}};

        repeat (2) @(negedge clk);
        chk("rst_nwr", {31'd0, nwr}, 32'd1);
        chk("rst_addr", {20'd0, caddr}, 32'd0);
        chk("rst_data", {24'd0, cdata}, 32'd0);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // single write timing
        @(negedge clk);
        addr[11:0] = 12'h05C;
        data[7:0]  = 8'h33;
        push(0);
        req = 4'b0001;
        @(negedge clk);
        chk("t1_addr", {20'd0, caddr}, 32'h05C);
        chk("t1_data", {24'd0, cdata}, 32'h33);
        chk("t1_nwr_setup", {31'd0, nwr}, 32'd1);
        chk("t1_busy_e0", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_nwr_low", {31'd0, nwr}, 32'd0);
        chk("t1_busy_e1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_ack", {28'd0, ack}, 32'd1);
        chk("t1_busy_e2", {31'd0, busy}, 32'd1);
        req = 4'd0;
        @(negedge clk);
        chk("t1_busy_e3", {31'd0, busy}, 32'd0);
        chk("t1_ack_off", {28'd0, ack}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_addr_held", {20'd0, caddr}, 32'h05C);
        chk("t1_data_held", {24'd0, cdata}, 32'h33);

        // all four held continuously from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            addr[i*12 +: 12] = 12'h080 + 12'(i);
            data[i*8 +: 8]   = 8'h30 + 8'(i);
        end
        push(0); push(1); push(2); push(3); push(0);
        run(4'b1111, 5, 0);

        // table of request patterns, drop on own ack
        do_reset();
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 4; i++) begin
                addr[i*12 +: 12] = 12'h100 + 12'(v * 16 + i);
                data[i*8 +: 8]   = 8'h40 + 8'(v * 4 + i);
            end
            for (int k = 0; k < vt[v].n; k++) push(int'(vt[v].ord[k*2 +: 2]));
            run(vt[v].mask, vt[v].n, 1);
        end
        chk("table_sb_empty", sbq.size(), 32'd0);

        // back-to-back from requester 1
        addr[23:12] = 12'h200;
        data[15:8]  = 8'h34;
        push(1);
        data[15:8]  = 8'h35;
        push(1);
        data[15:8]  = 8'h34;
        s1 = -1; s2 = -1; nack = 0; cyc = 0;
        @(negedge clk);
        req = 4'b0010;
        while (nack < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!nwr) begin
                if (s1 < 0) s1 = cyc;
                else s2 = cyc;
            end
            if (ack[1]) begin
                nack++;
                data[15:8] = 8'h35;
                if (nack == 2) req = 4'd0;
            end
        end
        chk("b2b_gap", s2 - s1, 32'd4);
        repeat (4) @(negedge clk);

        // reset mid-write
        do_reset();
        addr[11:0]  = 12'h300; data[7:0]   = 8'h41;
        addr[35:24] = 12'h302; data[23:16] = 8'h42;
        push(0);
        @(negedge clk);
        req = 4'b0101;
        cyc = 0;
        while (nwr && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_saw_strobe", {31'd0, nwr}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_nwr_async", {31'd0, nwr}, 32'd1);
        chk("t4_ack_async", {28'd0, ack}, 32'd0);
        chk("t4_busy_async", {31'd0, busy}, 32'd0);
        ack_due = 0;
        sbq.delete();
        push(0); push(2);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'b0101, 2, 1);

        // blank gating
        addr[11:0] = 12'h3A0;
        data[7:0]  = 8'h50;
        push(0);
`ifdef CHARWR_BLANK_ONLY_EN
        blank_n = 1'b1;
        @(negedge clk);
        req = 4'b0001;
        repeat (5) @(negedge clk);
        chk("t5_no_grant_active", {31'd0, busy}, 32'd0);
        blank_n = 1'b0;
        @(negedge clk);
        chk("t5_grant_blank", {31'd0, busy}, 32'd1);
        blank_n = 1'b1;
`else
        blank_n = 1'b1;
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        chk("t5_grant_next", {31'd0, busy}, 32'd1);
`endif
        nack = 0; cyc = 0;
        while (nack == 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ack[0]) begin
                nack++;
                req = 4'd0;
            end
        end
        chk("t5_completed", nack, 32'd1);
        blank_n = 1'b0;
        repeat (4) @(negedge clk);

        // withdrawn request still completes once
        addr[47:36] = 12'h3F0;
        data[31:24] = 8'h5A;
        push(3);
        @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        chk("t6_granted", {31'd0, busy}, 32'd1);
        @(negedge clk);
        req = 4'd0;
        nack = 0;
        for (int c = 0; c < 10; c++) begin
            if (ack == 4'b1000) nack++;
            @(negedge clk);
        end
        chk("t6_one_ack", nack, 32'd1);
        chk("t6_idle", {31'd0, busy}, 32'd0);
        chk("final_sb_empty", sbq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
